// File: rtl/pwm_cmp_bank_if.sv
// Register write bus feeding the compare bank: byte-wide writes qualified by a
// single-cycle valid strobe.
interface pwm_cmp_bank_if #(
   parameter int unsigned REGBITS = 5
);
   logic [REGBITS-1:0] reg_addr;
   logic [7:0]         reg_data;
   logic               reg_valid;

   modport master (
      output reg_addr,
      output reg_data,
      output reg_valid
   );

   modport slave (
      input reg_addr,
      input reg_data,
      input reg_valid
   );
endinterface

// File: rtl/pwm_cmp_bank.sv
// Double-buffered per-channel compare bank: byte writes assemble scratch values,
// commits move them to a pending stage, and period_start strobes apply them to
// the live compare outputs so a PWM period never sees a partially written value.
// Optional build macro CMP_SLEW_EN: live compare slews toward its target by at
// most STEP per period instead of jumping.
module pwm_cmp_bank #(
   parameter int unsigned       NCH       = 2,
   parameter int unsigned       WIDTH     = 20,
   parameter int unsigned       REGBITS   = 5,
   parameter logic [WIDTH-1:0]  RESET_CMP = 20'hA0002,
   parameter int unsigned       STEP      = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pwm_cmp_bank_if.slave        reg_bus,
   input  logic [NCH-1:0]       period_start,
   output logic [NCH*WIDTH-1:0] cmp,
   output logic [NCH-1:0]       pending,
   output logic [NCH-1:0]       slewing
);

   // Elaboration-time sanity checks on the configuration.
   if (NCH < 1 || NCH > 8) begin : g_bad_nch
      $error("pwm_cmp_bank: NCH out of range");
   end
   if (WIDTH < 9 || WIDTH > 24) begin : g_bad_width
      $error("pwm_cmp_bank: WIDTH out of range");
   end
   if ((1 << REGBITS) <= NCH * 4) begin : g_bad_regbits
      $error("pwm_cmp_bank: REGBITS too small for channel windows");
   end
   if (STEP < 1) begin : g_bad_step
      $error("pwm_cmp_bank: STEP must be at least 1");
   end

   localparam logic [REGBITS-1:0] GlobalAddr = REGBITS'(4 * NCH);

   logic [WIDTH-1:0] scratch_q [NCH];
   logic [WIDTH-1:0] scratch_d [NCH];
   logic [WIDTH-1:0] pend_q    [NCH];
   logic [WIDTH-1:0] pend_d    [NCH];
   logic [WIDTH-1:0] target_q  [NCH];
   logic [WIDTH-1:0] target_d  [NCH];
   logic [WIDTH-1:0] cmp_q     [NCH];
   logic [WIDTH-1:0] cmp_d     [NCH];
   logic [NCH-1:0]   pending_q, pending_d;
   logic [NCH-1:0]   slewing_q, slewing_d;

   logic glob_commit;
   logic chan_sel;
   logic do_commit;

`ifdef CMP_SLEW_EN
   localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] mag;
   logic [WIDTH-1:0] step;
`endif

   // Next-state: register decode, commit/apply sequencing and optional slew.
   always_comb begin
      scratch_d   = scratch_q;
      pend_d      = pend_q;
      target_d    = target_q;
      cmp_d       = cmp_q;
      pending_d   = pending_q;
      slewing_d   = '0;
      chan_sel    = 1'b0;
      do_commit   = 1'b0;
      glob_commit = reg_bus.reg_valid && (reg_bus.reg_addr == GlobalAddr);
`ifdef CMP_SLEW_EN
      diff = '0;
      mag  = '0;
      step = '0;
`endif
      for (int c = 0; c < NCH; c++) begin
         chan_sel = reg_bus.reg_valid &&
                    (reg_bus.reg_addr[REGBITS-1:2] == (REGBITS-2)'(c));

         // Byte lanes above WIDTH simply have no bits to land in.
         if (chan_sel && reg_bus.reg_addr[1:0] != 2'd3) begin
            for (int b = 0; b < WIDTH; b++) begin
               if ((b / 8) == int'(reg_bus.reg_addr[1:0])) begin
                  scratch_d[c][b] = reg_bus.reg_data[b % 8];
               end
            end
         end

         do_commit = glob_commit || (chan_sel && reg_bus.reg_addr[1:0] == 2'd3);

         // Apply uses the pre-edge pending value; a coincident commit then
         // reloads the pending stage and keeps the flag set.
         if (period_start[c] && pending_q[c]) begin
            target_d[c]  = pend_q[c];
            pending_d[c] = 1'b0;
         end
         if (do_commit) begin
            pend_d[c]    = scratch_q[c];
            pending_d[c] = 1'b1;
         end

`ifdef CMP_SLEW_EN
         if (period_start[c]) begin
            diff = {1'b0, target_d[c]} - {1'b0, cmp_q[c]};
            mag  = diff[WIDTH] ? (~diff[WIDTH-1:0] + 1'b1) : diff[WIDTH-1:0];
            step = (mag > StepW) ? StepW : mag;
            cmp_d[c] = diff[WIDTH] ? (cmp_q[c] - step) : (cmp_q[c] + step);
         end
         slewing_d[c] = (cmp_d[c] != target_d[c]);
`else
         if (period_start[c] && pending_q[c]) begin
            cmp_d[c] = target_d[c];
         end
`endif
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            scratch_q[c] <= RESET_CMP;
            pend_q[c]    <= RESET_CMP;
            target_q[c]  <= RESET_CMP;
            cmp_q[c]     <= RESET_CMP;
         end
         pending_q <= '0;
         slewing_q <= '0;
      end else begin
         scratch_q <= scratch_d;
         pend_q    <= pend_d;
         target_q  <= target_d;
         cmp_q     <= cmp_d;
         pending_q <= pending_d;
         slewing_q <= slewing_d;
      end
   end

   // Pack live compare registers onto the output bus.
   always_comb begin
      cmp = '0;
      for (int c = 0; c < NCH; c++) begin
         cmp[c*WIDTH +: WIDTH] = cmp_q[c];
      end
   end

   assign pending = pending_q;
   assign slewing = slewing_q;

endmodule

// File: tb/tb_pwm_cmp_bank.sv
// Directed bench for pwm_cmp_bank (NCH=2, WIDTH=20). Outputs are sampled on the
// falling edge; stimulus changes on the falling edge.
module tb_pwm_cmp_bank;

   localparam int unsigned NCH   = 2;
   localparam int unsigned WIDTH = 20;
   localparam int unsigned RB    = 5;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NCH-1:0]     period_start = '0;
   logic [NCH*WIDTH-1:0] cmp;
   logic [NCH-1:0]     pending;
   logic [NCH-1:0]     slewing;

   int n_assert = 0;
   int n_fail   = 0;

   pwm_cmp_bank_if #(.REGBITS(RB)) bus ();

   pwm_cmp_bank #(
      .NCH       (NCH),
      .WIDTH     (WIDTH),
      .REGBITS   (RB),
      .RESET_CMP (20'hA0002),
      .STEP      (256)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .reg_bus      (bus.slave),
      .period_start (period_start),
      .cmp          (cmp),
      .pending      (pending),
      .slewing      (slewing)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge with the given write and strobe values applied.
   task automatic cyc(input logic v, input logic [RB-1:0] a, input logic [7:0] d,
                      input logic [NCH-1:0] ps);
      bus.reg_valid = v;
      bus.reg_addr  = a;
      bus.reg_data  = d;
      period_start  = ps;
      @(negedge clk);
      bus.reg_valid = 1'b0;
      bus.reg_addr  = '0;
      bus.reg_data  = '0;
      period_start  = '0;
   endtask

   task automatic wr(input logic [RB-1:0] a, input logic [7:0] d);
      cyc(1'b1, a, d, 2'b00);
   endtask

   task automatic ps(input logic [NCH-1:0] s);
      cyc(1'b0, '0, 8'h00, s);
   endtask

   initial begin
      bus.reg_valid = 1'b0;
      bus.reg_addr  = '0;
      bus.reg_data  = '0;
      @(negedge clk);
      repeat (3) @(negedge clk);
      chk("rst_cmp0", 32'(cmp[19:0]), 32'h000A0002);
      chk("rst_cmp1", 32'(cmp[39:20]), 32'h000A0002);
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_slewing", 32'(slewing), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef CMP_SLEW_EN
      // Drive channel 0 to zero, then slew up to 0x300 in 0x100 steps.
      wr(5'd0, 8'h00);
      wr(5'd1, 8'h00);
      wr(5'd2, 8'h00);
      wr(5'd3, 8'h00);
      for (int i = 0; i < 3000 && cmp[19:0] != 20'h0; i++) ps(2'b01);
      chk("slew_drain", 32'(cmp[19:0]), 32'h0);
      chk("slew_drain_flag", 32'(slewing), 32'h0);
      wr(5'd1, 8'h03);
      wr(5'd3, 8'h00);
      ps(2'b01);
      chk("slew_s1", 32'(cmp[19:0]), 32'h100);
      chk("slew_s1_flag", 32'(slewing), 32'h1);
      ps(2'b01);
      chk("slew_s2", 32'(cmp[19:0]), 32'h200);
      chk("slew_s2_flag", 32'(slewing), 32'h1);
      ps(2'b01);
      chk("slew_s3", 32'(cmp[19:0]), 32'h300);
      chk("slew_s3_flag", 32'(slewing), 32'h0);
      wr(5'd1, 8'h10);
      wr(5'd3, 8'h00);
      ps(2'b01);
      chk("slew_mid", 32'(cmp[19:0]), 32'h400);
      chk("slew_mid_flag", 32'(slewing), 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("slew_rst_cmp", 32'(cmp[19:0]), 32'h000A0002);
      chk("slew_rst_flag", 32'(slewing), 32'h0);
`else
      // Channel 1 byte writes and commit.
      wr(5'd4, 8'h34);
      wr(5'd5, 8'h12);
      wr(5'd6, 8'h05);
      chk("ch1_no_pend", 32'(pending), 32'h0);
      wr(5'd7, 8'hAA);
      chk("ch1_pend", 32'(pending), 32'h2);
      chk("ch1_hold", 32'(cmp[39:20]), 32'h000A0002);
      ps(2'b01);
      chk("ch1_other_ps", 32'(cmp[39:20]), 32'h000A0002);
      chk("ch1_other_pend", 32'(pending), 32'h2);
      ps(2'b10);
      chk("ch1_apply", 32'(cmp[39:20]), 32'h00051234);
      chk("ch1_clear", 32'(pending), 32'h0);
      chk("ch0_untouched", 32'(cmp[19:0]), 32'h000A0002);

      // Byte 2 truncation and out-of-map address.
      wr(5'd6, 8'hFF);
      wr(5'd9, 8'h77);
      wr(5'd31, 8'h77);
      chk("ignored_addr", 32'(pending), 32'h0);
      wr(5'd7, 8'h00);
      ps(2'b10);
      chk("trunc", 32'(cmp[39:20]), 32'h000F1234);

      // Commit coinciding with channel 0 period start.
      wr(5'd0, 8'h00);
      wr(5'd1, 8'h01);
      wr(5'd2, 8'h00);
      wr(5'd3, 8'h00);
      wr(5'd1, 8'h02);
      cyc(1'b1, 5'd3, 8'h00, 2'b01);
      chk("coinc_old", 32'(cmp[19:0]), 32'h100);
      chk("coinc_pend", 32'(pending), 32'h1);
      ps(2'b01);
      chk("coinc_new", 32'(cmp[19:0]), 32'h200);
      chk("coinc_clear", 32'(pending), 32'h0);

      // Global commit, applied per channel.
      wr(5'd0, 8'h55);
      wr(5'd4, 8'h78);
      wr(5'd8, 8'h00);
      chk("glob_pend", 32'(pending), 32'h3);
      ps(2'b01);
      chk("glob_ch0", 32'(cmp[19:0]), 32'h255);
      chk("glob_ch1_hold", 32'(cmp[39:20]), 32'h000F1234);
      chk("glob_pend1", 32'(pending), 32'h2);
      ps(2'b10);
      chk("glob_ch1", 32'(cmp[39:20]), 32'h000F1278);
      chk("glob_clear", 32'(pending), 32'h0);
      chk("no_slew", 32'(slewing), 32'h0);

      // Reset mid-operation discards scratch and pending.
      wr(5'd0, 8'h11);
      wr(5'd3, 8'h00);
      chk("pre_rst_pend", 32'(pending), 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mrst_pend", 32'(pending), 32'h0);
      chk("mrst_cmp0", 32'(cmp[19:0]), 32'h000A0002);
      chk("mrst_cmp1", 32'(cmp[39:20]), 32'h000A0002);
      cyc(1'b1, 5'd3, 8'h00, 2'b01);
      chk("mrst_pend_again", 32'(pending), 32'h1);
      ps(2'b01);
      chk("mrst_scratch", 32'(cmp[19:0]), 32'h000A0002);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
